// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage buffer.
// Provides the skid FSM state encoding, the "no exception" code and the
// default exception-code width used by pipe_stage_buf and pipe_skid_ctrl.
package pipe_pkg;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } skid_state_e;

    localparam int unsigned EXC_W_DEFAULT = 5;
    localparam int unsigned EXC_NONE      = 0;

endpackage

// File: rtl/pipe_skid_ctrl.sv
// Control half of the two-entry pipeline stage buffer.
// Runs the EMPTY/ONE/TWO occupancy FSM and produces the handshake signals and
// the storage load strobes used by pipe_stage_buf.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   in_valid          upstream entry present
//   out_ready         downstream accepts
//   flush             discard all held entries
//   in_ready          buffer can accept
//   out_valid         head entry present
//   load_main         capture the incoming entry into the main register
//   load_skid         capture the incoming entry into the skid register
//   skid_to_main      move the skid entry into the main register
module pipe_skid_ctrl
    import pipe_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic in_valid,
    input  logic out_ready,
    input  logic flush,
    output logic in_ready,
    output logic out_valid,
    output logic load_main,
    output logic load_skid,
    output logic skid_to_main
);

    skid_state_e state_q, state_d;
    logic        has_q;
    logic        full_q;
    logic        in_fire;
    logic        out_fire;

    // Handshake flags are registered copies of the state decode; reset masks
    // them so nothing is offered or accepted while reset is held.
    assign in_ready  = ~full_q & ~reset;
    assign out_valid = has_q & ~reset;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_d      = state_q;
        load_main    = 1'b0;
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
        if (flush) begin
            // Incoming entry is dropped; a same-cycle out_fire is still consumed.
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (in_fire) begin
                        state_d   = StOne;
                        load_main = 1'b1;
                    end
                end
                StOne: begin
                    if (in_fire && out_fire) begin
                        load_main = 1'b1;
                    end else if (in_fire) begin
                        state_d   = StTwo;
                        load_skid = 1'b1;
                    end else if (out_fire) begin
                        state_d = StEmpty;
                    end
                end
                StTwo: begin
                    if (out_fire) begin
                        state_d      = StOne;
                        skid_to_main = 1'b1;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StEmpty;
            has_q   <= 1'b0;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            has_q   <= (state_d != StEmpty);
            full_q  <= (state_d == StTwo);
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// Two-entry pipeline stage buffer (main + skid register) with ready/valid
// handshakes on both sides, bubble/int_kill capture and flush.
// The main register drives out_*; the skid register absorbs one extra entry
// when the downstream stalls.
// Ports:
//   clk, reset              clock and synchronous active-high reset
//   in_valid/in_ready       upstream handshake
//   in_pc/instr/data/bd/exc incoming entry fields
//   bubble                  capture entry as bubble (instr/data/exc zeroed)
//   int_kill                capture entry with instr zeroed
//   flush                   discard all held entries
//   out_valid/out_ready     downstream handshake
//   out_pc/instr/data/bd/exc head entry fields
//   stall_cnt               backpressure cycle count, saturating; present only
//                           when PIPE_STAGE_STALL_CNT_EN is defined
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned EXC_W  = EXC_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_pc,
    input  logic [31:0]       in_instr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_bd,
    input  logic [EXC_W-1:0]  in_exc,
    input  logic              bubble,
    input  logic              int_kill,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_instr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_bd,
`ifdef PIPE_STAGE_STALL_CNT_EN
    output logic [31:0]       stall_cnt,
`endif
    output logic [EXC_W-1:0]  out_exc
);

    logic load_main;
    logic load_skid;
    logic skid_to_main;

    pipe_skid_ctrl u_ctrl (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .out_ready    (out_ready),
        .flush        (flush),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .load_main    (load_main),
        .load_skid    (load_skid),
        .skid_to_main (skid_to_main)
    );

    // Incoming entry after bubble/int_kill squashing; bubble dominates.
    logic [31:0]       cap_instr;
    logic [DATA_W-1:0] cap_data;
    logic [EXC_W-1:0]  cap_exc;

    always_comb begin
        cap_instr = in_instr;
        cap_data  = in_data;
        cap_exc   = in_exc;
        if (bubble) begin
            cap_instr = '0;
            cap_data  = '0;
            cap_exc   = EXC_W'(EXC_NONE);
        end else if (int_kill) begin
            cap_instr = '0;
        end
    end

    logic [31:0]       main_pc_q, skid_pc_q;
    logic [31:0]       main_instr_q, skid_instr_q;
    logic [DATA_W-1:0] main_data_q, skid_data_q;
    logic              main_bd_q, skid_bd_q;
    logic [EXC_W-1:0]  main_exc_q, skid_exc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            main_pc_q    <= '0;
            main_instr_q <= '0;
            main_data_q  <= '0;
            main_bd_q    <= 1'b0;
            main_exc_q   <= '0;
        end else if (load_main) begin
            main_pc_q    <= in_pc;
            main_instr_q <= cap_instr;
            main_data_q  <= cap_data;
            main_bd_q    <= in_bd;
            main_exc_q   <= cap_exc;
        end else if (skid_to_main) begin
            main_pc_q    <= skid_pc_q;
            main_instr_q <= skid_instr_q;
            main_data_q  <= skid_data_q;
            main_bd_q    <= skid_bd_q;
            main_exc_q   <= skid_exc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
            skid_data_q  <= '0;
            skid_bd_q    <= 1'b0;
            skid_exc_q   <= '0;
        end else if (load_skid) begin
            skid_pc_q    <= in_pc;
            skid_instr_q <= cap_instr;
            skid_data_q  <= cap_data;
            skid_bd_q    <= in_bd;
            skid_exc_q   <= cap_exc;
        end
    end

    assign out_pc    = main_pc_q;
    assign out_instr = main_instr_q;
    assign out_data  = main_data_q;
    assign out_bd    = main_bd_q;
    assign out_exc   = main_exc_q;

`ifdef PIPE_STAGE_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (out_valid && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
module tb_pipe_stage_buf;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned EXC_W  = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_pc;
    logic [31:0]       in_instr;
    logic [DATA_W-1:0] in_data;
    logic              in_bd;
    logic [EXC_W-1:0]  in_exc;
    logic              bubble;
    logic              int_kill;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_pc;
    logic [31:0]       out_instr;
    logic [DATA_W-1:0] out_data;
    logic              out_bd;
    logic [EXC_W-1:0]  out_exc;
`ifdef PIPE_STAGE_STALL_CNT_EN
    logic [31:0]       stall_cnt;
`endif

    always #5 clk = ~clk;

    pipe_stage_buf #(
        .DATA_W (DATA_W),
        .EXC_W  (EXC_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .in_data   (in_data),
        .in_bd     (in_bd),
        .in_exc    (in_exc),
        .bubble    (bubble),
        .int_kill  (int_kill),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .out_data  (out_data),
        .out_bd    (out_bd),
`ifdef PIPE_STAGE_STALL_CNT_EN
        .stall_cnt (stall_cnt),
`endif
        .out_exc   (out_exc)
    );

    typedef struct packed {
        logic [31:0]       pc;
        logic [31:0]       instr;
        logic [DATA_W-1:0] data;
        logic              bd;
        logic [EXC_W-1:0]  exc;
    } ent_t;

    ent_t sb[$];
    ent_t cur_exp;
    int   occ;
    int   n_tests;
    int   n_fail;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one upstream entry (or idle) and form its expected stored image.
    task automatic drv(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                       input logic [63:0] data, input logic bd, input logic [4:0] exc,
                       input logic bub, input logic kill);
        in_valid = v;
        in_pc    = pc;
        in_instr = instr;
        in_data  = data;
        in_bd    = bd;
        in_exc   = exc;
        bubble   = bub;
        int_kill = kill;
        cur_exp.pc    = pc;
        cur_exp.bd    = bd;
        cur_exp.instr = (bub || kill) ? 32'd0 : instr;
        cur_exp.data  = bub ? '0 : data;
        cur_exp.exc   = bub ? '0 : exc;
    endtask

    task automatic idle();
        drv(1'b0, 32'd0, 32'd0, 64'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    // Check handshakes and head entry against the occupancy model and the
    // scoreboard, then advance one clock and update the model.
    task automatic tick();
        bit ifire;
        bit ofire;
        ent_t e;
        @(negedge clk);
        check("in_ready", 64'(in_ready), 64'((occ < 2) && !reset));
        check("out_valid", 64'(out_valid), 64'((occ > 0) && !reset));
        ifire = in_valid && (occ < 2) && !reset;
        ofire = (occ > 0) && out_ready && !reset;
        if ((occ > 0) && !reset) begin
            e = sb[0];
            check("out_pc", 64'(out_pc), 64'(e.pc));
            check("out_instr", 64'(out_instr), 64'(e.instr));
            check("out_data", 64'(out_data), 64'(e.data));
            check("out_bd", 64'(out_bd), 64'(e.bd));
            check("out_exc", 64'(out_exc), 64'(e.exc));
            if (ofire) void'(sb.pop_front());
        end
        if (reset || flush) begin
            sb.delete();
            occ = 0;
        end else begin
            if (ifire) sb.push_back(cur_exp);
            occ = occ + int'(ifire) - int'(ofire);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        occ       = 0;
        reset     = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        idle();
        tick();
        // Fields cleared by reset.
        @(negedge clk);
        check("rst_pc", 64'(out_pc), 64'd0);
        check("rst_instr", 64'(out_instr), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_exc", 64'(out_exc), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Streaming.
        out_ready = 1'b1;
        drv(1'b1, 32'h3000, 32'h1111_0000, 64'hA0, 1'b0, 5'd0, 1'b0, 1'b0); tick();
        drv(1'b1, 32'h3004, 32'h1111_0004, 64'hA4, 1'b0, 5'd1, 1'b0, 1'b0); tick();
        drv(1'b1, 32'h3008, 32'h1111_0008, 64'hA8, 1'b1, 5'd2, 1'b0, 1'b0); tick();
        idle(); tick(); tick();

        // Backpressure: fill both entries, third push refused, then drain.
        out_ready = 1'b0;
        drv(1'b1, 32'h3000, 32'h2222_0000, 64'hB0, 1'b0, 5'd0, 1'b0, 1'b0); tick();
        drv(1'b1, 32'h3004, 32'h2222_0004, 64'hB4, 1'b1, 5'd3, 1'b0, 1'b0); tick();
        drv(1'b1, 32'h3008, 32'h2222_0008, 64'hB8, 1'b0, 5'd0, 1'b0, 1'b0); tick();
        idle(); tick(); tick();
        out_ready = 1'b1;
        tick(); tick(); tick();

        // Bubble.
        drv(1'b1, 32'h3010, 32'h8C01_0004, 64'hDEAD_BEEF, 1'b1, 5'd4, 1'b1, 1'b0); tick();
        idle(); tick();
        // int_kill.
        drv(1'b1, 32'h3014, 32'h0022_1820, 64'h1234_5678_9ABC, 1'b0, 5'd0, 1'b0, 1'b1); tick();
        // Both bubble and int_kill behave as bubble.
        drv(1'b1, 32'h3018, 32'hFFFF_FFFF, 64'h55, 1'b1, 5'd7, 1'b1, 1'b1); tick();
        idle(); tick(); tick();

        // Flush from TWO with an incoming entry.
        out_ready = 1'b0;
        drv(1'b1, 32'h3020, 32'h3333_0000, 64'hC0, 1'b0, 5'd0, 1'b0, 1'b0); tick();
        drv(1'b1, 32'h3024, 32'h3333_0004, 64'hC4, 1'b0, 5'd0, 1'b0, 1'b0); tick();
        drv(1'b1, 32'h4000, 32'h4444_0000, 64'hD0, 1'b0, 5'd0, 1'b0, 1'b0);
        flush = 1'b1; tick();
        flush = 1'b0;
        idle(); out_ready = 1'b1; tick(); tick();

        // Flush in ONE with a simultaneous out_fire.
        drv(1'b1, 32'h3030, 32'h5555_0000, 64'hE0, 1'b0, 5'd0, 1'b0, 1'b0); tick();
        drv(1'b1, 32'h3034, 32'h5555_0004, 64'hE4, 1'b0, 5'd0, 1'b0, 1'b0);
        flush = 1'b1; tick();
        flush = 1'b0;
        idle(); tick();

        // Reset mid-transfer, then in_ready in first cycle after reset.
        out_ready = 1'b0;
        drv(1'b1, 32'h3040, 32'h6666_0000, 64'hF0, 1'b0, 5'd0, 1'b0, 1'b0); tick();
        drv(1'b1, 32'h3044, 32'h6666_0004, 64'hF4, 1'b0, 5'd0, 1'b0, 1'b0); tick();
        reset = 1'b1; tick();
        reset = 1'b0; idle(); tick();

`ifdef PIPE_STAGE_STALL_CNT_EN
        reset = 1'b1; tick();
        reset = 1'b0;
        drv(1'b1, 32'h3050, 32'h7777_0000, 64'h10, 1'b0, 5'd0, 1'b0, 1'b0); tick();
        idle();
        for (int i = 0; i < 10; i++) tick();
        @(negedge clk);
        check("stall_cnt", 64'(stall_cnt), 64'd10);
        @(posedge clk);
        #1;
        reset = 1'b1; tick();
        @(negedge clk);
        check("stall_cnt_rst", 64'(stall_cnt), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 SHALL have parameter DATA_W, default 64, width of the operand payload (rs/rt/ext bundle).
REQ-002 SHALL have parameter EXC_W, default 5, width of the exception code.
REQ-003 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  buffer can accept.
- in_pc  in  32  entry PC.
- in_instr  in  32  instruction word.
- in_data  in  DATA_W  operand payload.
- in_bd  in  1  branch-delay-slot flag.
- in_exc  in  EXC_W  exception code (0 = none).
- bubble  in  1  capture entry as bubble.
- int_kill  in  1  squash captured instruction.
- flush  in  1  discard all held entries.
- out_valid  out  1  downstream entry present.
- out_ready  in  1  downstream accepts.
- out_pc, out_instr, out_data, out_bd, out_exc  out  32/32/DATA_W/1/EXC_W  head entry fields.
- stall_cnt  out  32  backpressure count (only with PIPE_STAGE_STALL_CNT_EN).

Function
REQ-004 SHALL hold up to 2 entries: a main register driving out_* and a skid register.
REQ-005 SHALL run FSM EMPTY / ONE / TWO; in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
REQ-006 SHALL drive in_ready = (state != TWO) & !reset, and out_valid = (state != EMPTY).
REQ-007 SHALL make these transitions:
- EMPTY + in_fire -> ONE, main loaded.
- ONE + in_fire & !out_fire -> TWO, skid loaded.
- ONE + out_fire & !in_fire -> EMPTY.
- ONE + both -> ONE, main reloaded.
- TWO + out_fire -> ONE, main <= skid.
- All other cases hold state and contents.
REQ-008 SHALL have latency 1 cycle: an entry accepted at edge N appears on out_* after edge N when the buffer was EMPTY or draining.
REQ-009 SHALL, when bubble=1 with in_fire, store instr=0, data=0 and exc=0, keeping in_pc and in_bd.
REQ-010 SHALL, when int_kill=1 with in_fire, store instr=0 and keep all other fields; bubble and int_kill together behave as bubble.
REQ-011 SHALL, on flush=1, go to EMPTY at the next edge regardless of in_fire/out_fire, dropping any incoming entry; an out_fire in the same cycle still counts as consumed.
REQ-012 SHALL never modify out_* field values while out_valid=1 and out_ready=0.
REQ-013 SHALL keep field values while in EMPTY; they are not meaningful.

Reset
REQ-014 SHALL, on reset at a clk edge, set state to EMPTY and clear all entry fields to 0; stall_cnt clears to 0.
REQ-015 SHALL give reset priority over flush, bubble, int_kill and the handshakes; reset mid-transfer loses all entries.
REQ-016 SHALL drive out_valid=0 and in_ready=0 while reset is high, and in_ready=1 in the first cycle after reset deasserts.

Configuration
REQ-017 SHALL, when macro PIPE_STAGE_STALL_CNT_EN is defined, increment stall_cnt each cycle with out_valid=1 and out_ready=0, saturating at 32'hFFFFFFFF.
REQ-018 SHALL, when PIPE_STAGE_STALL_CNT_EN is undefined, omit the stall_cnt port and counter logic, with all other behaviour identical.

Structure
REQ-019 SHALL take the FSM state encoding, EXC_NONE=0 and the default EXC_W from shared package pipe_pkg.
REQ-020 SHALL place the FSM and the ready/valid logic in sub-module pipe_skid_ctrl; entry storage stays in pipe_stage_buf.

Verification
REQ-021 SHALL cover streaming: out_ready=1, inputs pc=0x3000, 0x3004, 0x3008 on consecutive cycles -> same pcs on out_* one cycle later each, in_ready stays 1.
REQ-022 SHALL cover backpressure: out_ready=0, push pc=0x3000 then 0x3004 -> state TWO, in_ready=0; raise out_ready -> 0x3000 then 0x3004 emerge in order, none lost.
REQ-023 SHALL cover the bubble: in_instr=0x8C010004, pc=0x3010, bd=1, exc=4, bubble=1 -> out instr=0, data=0, exc=0, pc=0x3010, bd=1.
REQ-024 SHALL cover int_kill: instr=0x00221820, exc=0, int_kill=1 -> out instr=0, pc/data unchanged.
REQ-025 SHALL cover flush: state TWO, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, incoming entry absent.
REQ-026 SHALL cover the counter (macro defined): out_valid=1, out_ready=0 for 10 cycles -> stall_cnt=10; reset -> 0.
